// File: rtl/charattr_row_loader_pkg.sv
// Definitions shared by the char/attribute row-buffer writer and the video reader.
package charattr_row_loader_pkg;

  localparam int COLUMNS   = 80;
  localparam int BURST_LEN = 8;
  localparam int ROW_DEPTH = 88;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    RECEIVE,
    FINISH
  } loader_state_t;

endpackage

// File: rtl/charattr_row_loader.sv
// Fetches one text row of char+attribute words from the memory arbiter in fixed
// bursts and writes them to row-buffer addresses 0..COLUMNS-1 during blanking.
module charattr_row_loader #(
  parameter int COLUMNS        = charattr_row_loader_pkg::COLUMNS,
  parameter int BURST_LEN      = charattr_row_loader_pkg::BURST_LEN,
  parameter int ROW_ADDR_WIDTH = $clog2(charattr_row_loader_pkg::ROW_DEPTH),
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] row_base,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_ack,
  input  logic                      mem_valid,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic [ROW_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_en
);
  import charattr_row_loader_pkg::*;

  localparam int COL_W  = ROW_ADDR_WIDTH + 1;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  loader_state_t             state, state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] base, base_nxt, mem_addr_nxt;
  logic [COL_W-1:0]          col, col_nxt;
  logic [BEAT_W-1:0]         beat, beat_nxt;
  logic                      busy_nxt, done_nxt, mem_req_nxt, wr_en_nxt;
  logic [ROW_ADDR_WIDTH-1:0] wr_addr_nxt;
  logic [DATA_WIDTH-1:0]     wr_data_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      base     <= '0;
      col      <= '0;
      beat     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      base     <= base_nxt;
      col      <= col_nxt;
      beat     <= beat_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      mem_req  <= mem_req_nxt;
      mem_addr <= mem_addr_nxt;
      wr_en    <= wr_en_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
    end
  end

  // All outputs are registered; the RECEIVE cycle with a full beat count is the
  // trailing write cycle, where the burst/row decision is taken.
  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    col_nxt      = col;
    beat_nxt     = beat;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    mem_req_nxt  = 1'b0;
    mem_addr_nxt = mem_addr;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;

    unique case (state)
      IDLE: begin
        if (start) begin
          base_nxt     = row_base;
          col_nxt      = '0;
          mem_addr_nxt = row_base;
          mem_req_nxt  = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = REQUEST;
        end
      end
      REQUEST: begin
        busy_nxt = 1'b1;
        if (mem_ack) begin
          beat_nxt  = '0;
          state_nxt = RECEIVE;
        end else begin
          mem_req_nxt = 1'b1;
        end
      end
      RECEIVE: begin
        if (beat == BEAT_W'(BURST_LEN)) begin
          if (col < COL_W'(COLUMNS)) begin
            mem_addr_nxt = base + MEM_ADDR_WIDTH'(col);
            mem_req_nxt  = 1'b1;
            busy_nxt     = 1'b1;
            state_nxt    = REQUEST;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = FINISH;
          end
        end else begin
          busy_nxt = 1'b1;
          if (mem_valid) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = col[ROW_ADDR_WIDTH-1:0];
            wr_data_nxt = mem_data;
            col_nxt     = col + 1'b1;
            beat_nxt    = beat + 1'b1;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_charattr_row_loader.sv
// Directed bench for charattr_row_loader: an inline memory responder plus a write
// scoreboard, with a second instance covering the 88-column configuration.
module tb_charattr_row_loader;
  import charattr_row_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start80, start88, mem_ack, mem_valid;
  logic [23:0] row_base;
  logic [31:0] mem_data;

  logic        busyA, doneA, reqA, wenA;
  logic [23:0] addrA;
  logic [6:0]  waddrA;
  logic [31:0] wdataA;
  logic        busyB, doneB, reqB, wenB;
  logic [23:0] addrB;
  logic [6:0]  waddrB;
  logic [31:0] wdataB;

  int checks = 0;
  int errors = 0;
  int nWrites, badWrites, nDone, doneCycle, nReq, badAddr, reqDropped, maxAddr, otherWrites;
  logic        lastBusy;
  logic [23:0] reqAddr [16];

  always #5 clk = ~clk;

  charattr_row_loader dut (
    .clk(clk), .reset(reset), .start(start80), .row_base(row_base),
    .busy(busyA), .done(doneA), .mem_req(reqA), .mem_addr(addrA),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_data(mem_data),
    .wr_addr(waddrA), .wr_data(wdataA), .wr_en(wenA)
  );

  charattr_row_loader #(.COLUMNS(88)) dut88 (
    .clk(clk), .reset(reset), .start(start88), .row_base(row_base),
    .busy(busyB), .done(doneB), .mem_req(reqB), .mem_addr(addrB),
    .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_data(mem_data),
    .wr_addr(waddrB), .wr_data(wdataB), .wr_en(wenB)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Starts a row load on one instance and plays the arbiter until done (plus a
  // short tail) or until cycle stopAt; results land in the module-level counters.
  task automatic applyStimulus(input bit sel, input logic [23:0] base, input bit ackVary,
                               input bit gaps, input bit extra, input int midStart, input int stopAt);
    int cyc, rs, ackWait, beatsLeft, tail;
    logic [23:0] ptr, curAddr, expData, addr;
    logic req, wen, dn, bsy, oWen;
    logic [6:0] waddr;
    logic [31:0] wdata;
    nWrites = 0; badWrites = 0; nDone = 0; doneCycle = 0; nReq = 0; badAddr = 0;
    reqDropped = 0; maxAddr = 0; otherWrites = 0; lastBusy = 1'b0;
    rs = 0; ackWait = 0; beatsLeft = 0; tail = 0; ptr = '0; curAddr = '0;
    row_base = base;
    if (sel) start88 = 1'b1; else start80 = 1'b1;
    cyc = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      cyc++;
      start80 = 1'b0; start88 = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
      if (sel) begin
        req = reqB; addr = addrB; wen = wenB; waddr = waddrB; wdata = wdataB;
        dn = doneB; bsy = busyB; oWen = wenA;
      end else begin
        req = reqA; addr = addrA; wen = wenA; waddr = waddrA; wdata = wdataA;
        dn = doneA; bsy = busyA; oWen = wenB;
      end
      if (wen) begin
        expData = base + 24'(nWrites);
        if (waddr !== 7'(nWrites) || wdata !== {8'h00, expData}) badWrites++;
        if (int'(waddr) > maxAddr) maxAddr = int'(waddr);
        nWrites++;
      end
      if (oWen) otherWrites++;
      if (dn) begin
        nDone++;
        if (nDone == 1) doneCycle = cyc;
      end
      lastBusy = bsy;
      if (cyc == midStart) begin
        row_base = ~base;
        if (sel) start88 = 1'b1; else start80 = 1'b1;
      end
      if (rs == 0 && req) begin
        if (nReq < 16) reqAddr[nReq] = addr;
        if (addr !== base + 24'(8 * nReq)) badAddr++;
        nReq++;
        curAddr = addr;
        ackWait = ackVary ? (nReq * 7 + 1) % 6 : 0;
        rs = 1;
      end
      if (rs == 1) begin
        if (!req || addr !== curAddr) reqDropped++;
        if (ackWait == 0) begin
          mem_ack = 1'b1;
          beatsLeft = extra ? 9 : 8;
          ptr = curAddr;
          rs = 2;
        end else begin
          ackWait--;
        end
      end else if (rs == 2) begin
        if (!(gaps && (cyc % 3 == 0))) begin
          mem_valid = 1'b1;
          mem_data = {8'h00, ptr};
          ptr = ptr + 24'd1;
          beatsLeft--;
          if (beatsLeft == 0) rs = 0;
        end
      end
      if (nDone > 0) tail++;
      if (tail == 5 || cyc == stopAt) break;
    end
  endtask

  initial begin
    int lateDone;
    reset = 1'b0; start80 = 1'b0; start88 = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0;
    mem_data = '0; row_base = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busyA, 0);
    checkOutput("reset_done", doneA, 0);
    checkOutput("reset_mem_req", reqA, 0);
    checkOutput("reset_wr_en", wenA, 0);
    checkOutput("reset_mem_addr", addrA, 0);
    checkOutput("reset_wr_addr", waddrA, 0);
    checkOutput("reset_wr_data", wdataA, 0);
    checkOutput("reset_state", dut.state, IDLE);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] nominal row load");
    applyStimulus(0, 24'h001000, 0, 0, 0, 0, 0);
    checkOutput("t1_writes", nWrites, 80);
    checkOutput("t1_order", badWrites, 0);
    checkOutput("t1_done_count", nDone, 1);
    checkOutput("t1_latency", doneCycle, 102);
    checkOutput("t1_req_count", nReq, 10);
    checkOutput("t1_req_addr", badAddr, 0);
    checkOutput("t1_first_addr", reqAddr[0], 24'h001000);
    checkOutput("t1_last_addr", reqAddr[9], 24'h001048);
    checkOutput("t1_idle_after", lastBusy, 0);
    checkOutput("t1_other_idle", otherWrites, 0);

    $display("[TB] bubbles and ack delays");
    applyStimulus(0, 24'h001000, 1, 1, 0, 0, 0);
    checkOutput("t2_writes", nWrites, 80);
    checkOutput("t2_order", badWrites, 0);
    checkOutput("t2_done_count", nDone, 1);
    checkOutput("t2_req_held", reqDropped, 0);
    checkOutput("t2_req_addr", badAddr, 0);

    $display("[TB] address wrap");
    applyStimulus(0, 24'hFFFFF8, 0, 0, 0, 0, 0);
    checkOutput("t3_second_addr", reqAddr[1], 24'h000000);
    checkOutput("t3_writes", nWrites, 80);
    checkOutput("t3_order", badWrites, 0);

    $display("[TB] overrun beats and ignored start");
    applyStimulus(0, 24'h002000, 0, 0, 1, 40, 0);
    checkOutput("t4_writes", nWrites, 80);
    checkOutput("t4_order", badWrites, 0);
    checkOutput("t4_done_count", nDone, 1);
    checkOutput("t4_idle_after", lastBusy, 0);

    $display("[TB] reset mid-load");
    applyStimulus(0, 24'h003000, 0, 0, 0, 0, 35);
    mem_valid = 1'b0; mem_ack = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("t5_busy", busyA, 0);
    checkOutput("t5_done", doneA, 0);
    checkOutput("t5_mem_req", reqA, 0);
    checkOutput("t5_wr_en", wenA, 0);
    checkOutput("t5_mem_addr", addrA, 0);
    checkOutput("t5_wr_addr", waddrA, 0);
    checkOutput("t5_wr_data", wdataA, 0);
    checkOutput("t5_state", dut.state, IDLE);
    reset = 1'b1;
    lateDone = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (doneA) lateDone++;
    end
    checkOutput("t5_no_done", lateDone, 0);
    applyStimulus(0, 24'h004000, 0, 0, 0, 0, 0);
    checkOutput("t5_reload_writes", nWrites, 80);
    checkOutput("t5_reload_order", badWrites, 0);
    checkOutput("t5_reload_done", nDone, 1);

    $display("[TB] 88-column row");
    applyStimulus(1, 24'h005000, 0, 0, 0, 0, 0);
    checkOutput("t6_writes", nWrites, 88);
    checkOutput("t6_order", badWrites, 0);
    checkOutput("t6_max_addr", maxAddr, 87);
    checkOutput("t6_req_count", nReq, 11);
    checkOutput("t6_done_count", nDone, 1);
    checkOutput("t6_other_idle", otherWrites, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
